// File: rtl/stego_pkg.sv
// Shared constants and controller state type for the LSB-steganography decode path.
// Each payload byte is rebuilt from the low bits of GROUP consecutive carrier bytes.
package stego_pkg;

    localparam int LSB_BITS  = 2;
    localparam int GROUP     = 4;
    localparam int BYTE_W    = LSB_BITS * GROUP;
    localparam int HDR_BYTES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPT,
        ST_HDR,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } ctrl_state_t;

endpackage

// File: rtl/lsb_byte_assembler.sv
// Shifts LSB pairs from carrier bytes into a payload byte, MSB pair first.
// byte_done_o pulses on the load that completes a byte; acc_o then holds it from the next cycle.
module lsb_byte_assembler
    import stego_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [LSB_BITS-1:0] bits_i,
    output logic [BYTE_W-1:0]   acc_o,
    output logic                byte_done_o
);

    localparam int SUB_W = $clog2(GROUP);

    logic [BYTE_W-1:0] acc_q, acc_d;
    logic [SUB_W-1:0]  sub_q, sub_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        acc_d = acc_q;
        sub_d = sub_q;
        if (clear_i) begin
            acc_d = '0;
            sub_d = '0;
        end else if (load_i) begin
            acc_d = {acc_q[BYTE_W-LSB_BITS-1:0], bits_i};
            sub_d = sub_q + SUB_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            sub_q <= '0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

    assign acc_o       = acc_q;
    assign byte_done_o = load_i && !clear_i && (sub_q == SUB_W'(GROUP - 1));

endmodule

// File: rtl/stego_decode_ctrl.sv
// Decode sequencer: fetches carrier bytes, collects the big-endian length header,
// checks the carrier is long enough, then streams payload bytes over valid/ready.
module stego_decode_ctrl
    import stego_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int N_HDR  = HDR_BYTES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    carrier_len,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [7:0]           mem_rd_data,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [8*N_HDR-1:0]   payload_len
);

    localparam int LEN_W  = 8 * N_HDR;
    localparam int CNT_W  = LEN_W - 3;
    localparam int NEED_W = LEN_W + 2;
    localparam int IDX_W  = $clog2(N_HDR + 1);
    localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(N_HDR - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] clen_q, clen_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  emitted_q, emitted_d;
    logic [LEN_W-1:0]  plen_q, plen_d;
    logic [CNT_W-1:0]  n_bytes;
    logic [NEED_W-1:0] need;
    logic              asm_load, asm_clear, byte_done;
    logic [7:0]        acc;
    logic              unused_rd_bits;

    // Only the low carrier bits carry payload.
    assign unused_rd_bits = ^mem_rd_data[7:LSB_BITS];

    lsb_byte_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (asm_clear),
        .load_i      (asm_load),
        .bits_i      (mem_rd_data[LSB_BITS-1:0]),
        .acc_o       (acc),
        .byte_done_o (byte_done)
    );

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        clen_d    = clen_q;
        idx_d     = idx_q;
        emitted_d = emitted_q;
        plen_d    = plen_q;
        asm_load  = 1'b0;
        asm_clear = 1'b0;
        n_bytes   = plen_q[LEN_W-1:3];
        need      = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    rd_ptr_d  = '0;
                    clen_d    = carrier_len;
                    idx_d     = '0;
                    emitted_d = '0;
                    plen_d    = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_FETCH: state_d = (rd_ptr_q == clen_q) ? ST_ERR : ST_CAPT;
            ST_CAPT: begin
                asm_load = 1'b1;
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                if (byte_done) state_d = (idx_q <= HDR_LAST) ? ST_HDR : ST_EMIT;
                else           state_d = ST_FETCH;
            end
            ST_HDR: begin
                for (int i = 0; i < N_HDR; i++) begin
                    if (idx_q == IDX_W'(i)) plen_d[LEN_W-1-8*i -: 8] = acc;
                end
                idx_d   = idx_q + IDX_W'(1);
                n_bytes = plen_d[LEN_W-1:3];
                need    = (NEED_W'(n_bytes) + NEED_W'(N_HDR)) << 2;
                state_d = ST_FETCH;
                // Reject an oversized header before any payload byte goes out.
                if (idx_q == HDR_LAST) begin
                    if (n_bytes == '0)              state_d = ST_DONE;
                    else if (need > NEED_W'(clen_q)) state_d = ST_ERR;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    emitted_d = emitted_q + CNT_W'(1);
                    state_d   = (emitted_d == n_bytes) ? ST_DONE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            clen_q    <= '0;
            idx_q     <= '0;
            emitted_q <= '0;
            plen_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            clen_q    <= clen_d;
            idx_q     <= idx_d;
            emitted_q <= emitted_d;
            plen_q    <= plen_d;
        end
    end

    assign mem_rd_en   = (state_q == ST_FETCH) && (rd_ptr_q != clen_q);
    assign mem_addr    = mem_rd_en ? rd_ptr_q : '0;
    assign out_valid   = (state_q == ST_EMIT);
    assign out_data    = acc;
    assign busy        = (state_q == ST_FETCH) || (state_q == ST_CAPT) ||
                         (state_q == ST_HDR)   || (state_q == ST_EMIT);
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);
    assign payload_len = plen_q;

endmodule

// File: tb/tb_stego_decode_ctrl.sv
// Self-checking bench: builds carrier images from payload bytes and compares the decoded
// stream, status flags and read traffic with expectations derived from the length header.
module tb_stego_decode_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] carrier_len = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready = 1'b0;
    logic              busy, done, err;
    logic [23:0]       payload_len;

    stego_decode_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .carrier_len (carrier_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .payload_len (payload_len)
    );

    always #5 clk = ~clk;

    // Carrier RAM: synchronous read, data one cycle after the strobe.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr[7:0]];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    int                rd_cnt, valid_cyc, oob_cnt, stab_bad, cur_clen;
    logic [ADDR_W-1:0] max_addr;
    logic [7:0]        got[$];
    logic              hold_prev;
    logic [7:0]        prev_data;
    bit                mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            rd_cnt    <= 0;
            valid_cyc <= 0;
            oob_cnt   <= 0;
            stab_bad  <= 0;
            max_addr  <= '0;
            hold_prev <= 1'b0;
            got.delete();
        end else begin
            if (mem_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (mem_addr > max_addr) max_addr <= mem_addr;
                if (int'(mem_addr) >= cur_clen) oob_cnt <= oob_cnt + 1;
            end
            if (out_valid) valid_cyc <= valid_cyc + 1;
            if (out_valid && out_ready) got.push_back(out_data);
            if (hold_prev && (!out_valid || out_data !== prev_data)) stab_bad <= stab_bad + 1;
            hold_prev <= out_valid && !out_ready;
            prev_data <= out_data;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Each payload byte becomes four carrier bytes with random upper bits.
    task automatic put_byte(input int idx, input logic [7:0] b);
        logic [5:0] r;
        for (int k = 0; k < 4; k++) begin
            r = 6'($urandom);
            ram[4*idx+k] = {r, b[7-2*k -: 2]};
        end
    endtask

    task automatic fill_ram(input logic [23:0] hdr, input logic [7:0] pay[$]);
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        put_byte(0, hdr[23:16]);
        put_byte(1, hdr[15:8]);
        put_byte(2, hdr[7:0]);
        foreach (pay[i]) if (i < 60) put_byte(3 + i, pay[i]);
    endtask

    task automatic run_case(input string name, input logic [23:0] hdr, input int clen, input bit rnd_ready);
        logic [7:0] pay[$];
        int  n, need, e_reads, e_out;
        bit  e_done, e_err, fin;
        n = int'(hdr >> 3);
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        fill_ram(hdr, pay);
        cur_clen = clen;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        carrier_len = ADDR_W'(clen);
        @(posedge clk); #1;
        start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = rnd_ready ? 1'($urandom) : 1'b1;
            @(posedge clk); #1;
            if (done || err) begin
                fin = 1'b1;
                break;
            end
        end
        check({name, " finished"}, 32'(fin), 32'd1);

        need = 4 * (3 + n);
        e_done = 1'b0; e_err = 1'b0; e_out = 0;
        if (clen < 12) begin
            e_err = 1'b1; e_reads = clen;
        end else if (n == 0) begin
            e_done = 1'b1; e_reads = 12;
        end else if (need > clen) begin
            e_err = 1'b1; e_reads = 12;
        end else begin
            e_done = 1'b1; e_reads = need; e_out = n;
        end

        check({name, " done"}, 32'(done), 32'(e_done));
        check({name, " err"}, 32'(err), 32'(e_err));
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " reads"}, 32'(rd_cnt), 32'(e_reads));
        check({name, " out_count"}, 32'(got.size()), 32'(e_out));
        for (int i = 0; i < e_out && i < got.size(); i++)
            check($sformatf("%s byte%0d", name, i), 32'(got[i]), 32'(pay[i]));
        if (e_out == 0) check({name, " no_valid"}, 32'(valid_cyc), 32'd0);
        if (e_reads > 0) check({name, " max_addr"}, 32'(max_addr), 32'(e_reads - 1));
        check({name, " addr_bound"}, 32'(oob_cnt), 32'd0);
        check({name, " stable"}, 32'(stab_bad), 32'd0);
        if (clen >= 12) check({name, " payload_len"}, 32'(payload_len), 32'(hdr));
    endtask

    initial begin
        logic [7:0] abc[$];
        int lat, bad, rd_snap, n, sel, clen;
        logic [23:0] hdr;
        bit fin;

        abc = '{8'h41, 8'h42, 8'h43};

        repeat (3) @(posedge clk);
        #1;
        check("reset flags", 32'({busy, done, err, out_valid, mem_rd_en}), 32'd0);
        check("reset payload_len", 32'(payload_len), 32'd0);
        rst_n = 1'b1;

        // ABC decode with a stalled consumer on the first byte.
        fill_ram(24'h000018, abc);
        cur_clen = 24;
        clear_mon();
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        carrier_len = ADDR_W'(24);
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (out_valid) break;
        end
        check("first_byte_latency", 32'(lat), 32'd36);
        check("first_byte_data", 32'(out_data), 32'h41);
        rd_snap = rd_cnt;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            if (c == 5) carrier_len = ADDR_W'(3);
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && out_data === 8'h41)) bad++;
        end
        start = 1'b0;
        check("hold_stable", 32'(bad), 32'd0);
        check("hold_no_reads", 32'(rd_cnt - rd_snap), 32'd0);
        out_ready = 1'b1;
        fin = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (done || err) begin
                fin = 1'b1;
                break;
            end
        end
        check("abc finished", 32'(fin), 32'd1);
        check("abc count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("abc byte%0d", i), 32'(got[i]), 32'(abc[i]));
        check("abc flags", 32'({done, err, busy, out_valid}), 32'b1000);
        check("abc reads", 32'(rd_cnt), 32'd24);
        check("abc payload_len", 32'(payload_len), 32'h18);

        // Boundary cases.
        run_case("zero_hdr", 24'h000000, 20, 1'b0);
        run_case("too_short", 24'h000050, 40, 1'b0);
        run_case("truncate", 24'h00000F, 16, 1'b1);
        run_case("short_carrier", 24'h000018, 7, 1'b0);
        run_case("exact_fit", 24'h000018, 24, 1'b1);

        // Reset in the middle of EMIT.
        fill_ram(24'h000018, abc);
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        carrier_len = ADDR_W'(24);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid) break;
        end
        check("rst reached emit", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst flags", 32'({busy, done, err, out_valid, mem_rd_en}), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst payload_len", 32'(payload_len), 32'd0);
        rst_n = 1'b1;
        run_case("post_reset", 24'h000018, 24, 1'b1);

        // Randomised headers and carrier lengths.
        for (int t = 0; t < 10; t++) begin
            n   = $urandom_range(0, 40);
            hdr = 24'(n * 8 + $urandom_range(0, 7));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       clen = 4 * (3 + n);
                1:       clen = 4 * (3 + n) + $urandom_range(1, 30);
                2:       clen = 4 * (3 + n) - $urandom_range(1, 4);
                default: clen = $urandom_range(0, 11);
            endcase
            run_case($sformatf("rand%0d", t), hdr, clen, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
